tt_um_top: RTL and testbench
============================

Name: tt_um_top

Overview:
- 4-digit keypad combination lock in the standard Tiny Tapeout user-project wrapper.
- Digits arrive on ui_in with a key-press strobe. Four digits are compared against a stored code; a match unlocks.
- Repeated failures trigger a timed lockout.
- While unlocked, the code can be reprogrammed; the programmed code is held until reset.

Parameters:
- DEFAULT_CODE, 16'h1234, code loaded at reset; digit 1 in [15:12], digit 4 in [3:0].
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (1..3).
- LOCKOUT_CYCLES, 1024, clock cycles spent in LOCKOUT (>=1, counter width = clog2+1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design-selected indicator; ignored.
- ui_in  input  8  [3:0] digit, [4] key strobe, [5] clear, [6] relock, [7] program request.
- uio_in  input  8  unused.
- uo_out  output  8  [0] unlocked, [1] error, [2] lockout, [3] program mode, [5:4] digits entered (0-3), [7:6] fail count.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state LOCKED; code register = DEFAULT_CODE.
  - digit count, fail count, error and lockout counter = 0.
  - all uo_out bits 0.
- Input synchronisation: ui_in[7:0] passes through a 2-flop synchroniser.
- Key press: rising edge of the synchronised ui_in[4] (a 3rd flop holds the previous value).
  - A one-cycle press event is generated; the digit is sampled from the synchronised ui_in[3:0] in that same cycle.
  - Holding the strobe high counts as one press.
- Digit 4'hA..4'hF is accepted like any digit; it can never match a decimal code but is storable.
- LOCKED / ENTRY:
  - Each press shifts the digit into the entry buffer and increments the digit count; the error flag clears on the first press.
  - On the 4th press (count 3 → wrap to 0), compare the buffer with the code register on the next cycle.
  - Match → UNLOCKED, fail count = 0.
  - Mismatch → error = 1, fail count++; if fail count reaches MAX_FAIL → LOCKOUT, else stay LOCKED.
  - Synchronised clear (ui_in[5] high): digit count = 0, buffer = 0, error = 0. Clear has priority over a press in the same cycle. Fail count is not cleared.
- UNLOCKED:
  - uo_out[0] = 1; key presses are ignored.
  - Relock (synchronised ui_in[6] high) → LOCKED, digit count 0. Relock has priority over program.
  - Program (synchronised ui_in[7] high) → PROGRAM, digit count 0.
- PROGRAM:
  - uo_out[0] = 1, uo_out[3] = 1.
  - Presses shift into the buffer. On the 4th press the code register takes the buffer → UNLOCKED.
  - Clear aborts: code unchanged → UNLOCKED.
  - Relock aborts: code unchanged → LOCKED.
- LOCKOUT:
  - uo_out[2] = 1; presses, clear and program are ignored.
  - Counter runs LOCKOUT_CYCLES cycles, then → LOCKED with fail count 0, error 0, digit count 0.
- Outputs are registered (or decoded from registered state only); no combinational path from ui_in to uo_out.
- Asserting rst_n low in any state (including mid-entry, PROGRAM or LOCKOUT) returns immediately to reset values. Any programmed code is lost.

Test Plan:
- Reset with ui_in = 0 → uo_out = 8'h00, uio_oe = 8'h00, uio_out = 8'h00.
- Press digits 1,2,3,4 (strobe high 2 cycles, low 2 cycles each) → uo_out[0] = 1, uo_out[7:6] = 0 within 5 cycles of the last press.
- Press 1,2,3,5 → uo_out[1] = 1, uo_out[7:6] = 1, uo_out[0] = 0. Then enter 1,2,3,4 → unlock and fail count = 0.
- Enter 3 wrong codes → uo_out[2] = 1; correct code presses during lockout are ignored. After LOCKOUT_CYCLES cycles → uo_out = 8'h00.
- Unlock, raise ui_in[7], enter 9,8,7,6 → uo_out[3] drops. Relock with ui_in[6], enter 1,2,3,4 → error set. Enter 9,8,7,6 → unlocked.
- Press 1,2, then pulse clear → uo_out[5:4] = 0. Press 1,2,3,4 → unlocked. Assert rst_n low mid-entry → uo_out = 0 immediately.

Source files
------------

// File: rtl/tt_um_top.sv
// Four-digit keypad combination lock for the Tiny Tapeout user-project wrapper.
// Synchronised key strobe, reprogrammable code, and a timed lockout after repeated failures.
module tt_um_top #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 1024
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int              CW         = $clog2(LOCKOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   LOCK_LAST  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]      FAIL_LIMIT = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_LOCKED,
        S_CHECK,
        S_UNLOCKED,
        S_PROGRAM,
        S_LOCKOUT
    } state_t;

    state_t          r_state;
    logic [7:0]      r_sync1;
    logic [7:0]      r_sync2;
    logic            r_strobe_d;
    logic [15:0]     r_buf;
    logic [15:0]     r_code;
    logic [1:0]      r_count;
    logic [1:0]      r_fail;
    logic            r_error;
    logic [CW-1:0]   r_lock_cnt;

    logic            w_press;
    logic [3:0]      w_digit;
    logic            w_clear;
    logic            w_relock;
    logic            w_prog;
    logic [15:0]     w_next_buf;
    logic [1:0]      w_fail_inc;
    logic            w_unlocked;
    logic            w_unused;

    assign w_press    = r_sync2[4] & ~r_strobe_d;
    assign w_digit    = r_sync2[3:0];
    assign w_clear    = r_sync2[5];
    assign w_relock   = r_sync2[6];
    assign w_prog     = r_sync2[7];
    assign w_next_buf = {r_buf[11:0], w_digit};
    assign w_fail_inc = r_fail + 2'd1;
    assign w_unused   = &{1'b0, ena, uio_in};

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_strobe_d <= 1'b0;
        end else begin
            r_sync1    <= ui_in;
            r_sync2    <= r_sync1;
            r_strobe_d <= r_sync2[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOCKED;
            r_buf      <= '0;
            r_code     <= DEFAULT_CODE;
            r_count    <= '0;
            r_fail     <= '0;
            r_error    <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            unique case (r_state)
                S_LOCKED: begin
                    if (w_clear) begin
                        r_count <= '0;
                        r_buf   <= '0;
                        r_error <= 1'b0;
                    end else if (w_press) begin
                        r_buf   <= w_next_buf;
                        r_error <= 1'b0;
                        r_count <= r_count + 2'd1;
                        if (r_count == 2'd3) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                // The full entry is compared one cycle after the fourth press lands.
                S_CHECK: begin
                    r_buf <= '0;
                    if (r_buf == r_code) begin
                        r_state <= S_UNLOCKED;
                        r_fail  <= '0;
                    end else begin
                        r_error <= 1'b1;
                        r_fail  <= w_fail_inc;
                        if (w_fail_inc == FAIL_LIMIT) begin
                            r_state    <= S_LOCKOUT;
                            r_lock_cnt <= '0;
                        end else begin
                            r_state <= S_LOCKED;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (w_relock) begin
                        r_state <= S_LOCKED;
                        r_count <= '0;
                        r_buf   <= '0;
                    end else if (w_prog) begin
                        r_state <= S_PROGRAM;
                        r_count <= '0;
                        r_buf   <= '0;
                    end
                end
                S_PROGRAM: begin
                    if (w_relock) begin
                        r_state <= S_LOCKED;
                        r_count <= '0;
                        r_buf   <= '0;
                    end else if (w_clear) begin
                        r_state <= S_UNLOCKED;
                        r_count <= '0;
                        r_buf   <= '0;
                    end else if (w_press) begin
                        r_buf   <= w_next_buf;
                        r_count <= r_count + 2'd1;
                        if (r_count == 2'd3) begin
                            r_code  <= w_next_buf;
                            r_state <= S_UNLOCKED;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (r_lock_cnt == LOCK_LAST) begin
                        r_state    <= S_LOCKED;
                        r_fail     <= '0;
                        r_error    <= 1'b0;
                        r_count    <= '0;
                        r_buf      <= '0;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: r_state <= S_LOCKED;
            endcase
        end
    end

    assign w_unlocked = (r_state == S_UNLOCKED) || (r_state == S_PROGRAM);

    assign uo_out  = {r_fail, r_count, (r_state == S_PROGRAM), (r_state == S_LOCKOUT),
                      r_error, w_unlocked};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_top.sv
// Directed bench for the keypad lock: unlock, failures, lockout timing, programming,
// clear and asynchronous reset, each checked against hand-computed uo_out values.
module tb_tt_um_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    tt_um_top dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic press(input logic [3:0] d, input int hold = 2);
        ui_in[3:0] = d;
        ui_in[4]   = 1'b1;
        tick(hold);
        ui_in[4]   = 1'b0;
        tick(2);
    endtask

    task automatic enter(input logic [15:0] code);
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
        tick(1);
    endtask

    task automatic pulse(input int idx);
        ui_in[idx] = 1'b1;
        tick(1);
        ui_in[idx] = 1'b0;
        tick(3);
    endtask

    task automatic expect_uo(input string name, input logic [7:0] exp);
        vectors++;
        if (uo_out !== exp) begin
            miscompares++;
            $display("FAIL %s: uo_out=%02h expected=%02h", name, uo_out, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ui_in = 8'h00;
        tick(2);
        expect_uo("reset_uo_out", 8'h00);
        vectors++;
        if (uio_oe !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uio_oe: got=%02h expected=00", uio_oe);
        end
        vectors++;
        if (uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uio_out: got=%02h expected=00", uio_out);
        end
        rst_n = 1'b1;
        tick(2);
        expect_uo("after_release", 8'h00);
    endtask

    task automatic test_unlock;
        enter(16'h1234);
        expect_uo("unlock_default", 8'h01);
        pulse(6);
        expect_uo("relock", 8'h00);
    endtask

    task automatic test_wrong_then_right;
        enter(16'h1235);
        expect_uo("wrong_once", 8'h42);
        press(4'h1);
        expect_uo("error_cleared_first_press", 8'h50);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        tick(1);
        expect_uo("right_after_wrong", 8'h01);
        pulse(6);
        expect_uo("relock2", 8'h00);
    endtask

    task automatic test_lockout;
        int start;
        int guard;
        enter(16'h1111);
        expect_uo("fail1", 8'h42);
        enter(16'hA234);
        expect_uo("fail2", 8'h82);
        enter(16'h4321);
        start = cyc - 1;
        expect_uo("lockout_entered", 8'hC6);
        enter(16'h1234);
        pulse(5);
        pulse(7);
        expect_uo("lockout_ignores_input", 8'hC6);
        guard = 0;
        while (uo_out[2] === 1'b1 && guard < 1200) begin
            tick(1);
            guard++;
        end
        vectors++;
        if (cyc - start != 1024) begin
            miscompares++;
            $display("FAIL lockout_duration: cycles=%0d expected=1024", cyc - start);
        end
        expect_uo("lockout_exit", 8'h00);
    endtask

    task automatic test_clear;
        press(4'h1);
        press(4'h2);
        expect_uo("two_digits", 8'h20);
        pulse(5);
        expect_uo("clear", 8'h00);
        press(4'h1, 6);
        expect_uo("held_strobe_one_press", 8'h10);
        ui_in[5]   = 1'b1;
        ui_in[3:0] = 4'h7;
        ui_in[4]   = 1'b1;
        tick(1);
        ui_in[5]   = 1'b0;
        tick(1);
        ui_in[4]   = 1'b0;
        tick(3);
        expect_uo("clear_beats_press", 8'h00);
        enter(16'h1234);
        expect_uo("unlock_after_clear", 8'h01);
        pulse(6);
    endtask

    task automatic test_program;
        enter(16'h1234);
        expect_uo("unlock_for_prog", 8'h01);
        pulse(7);
        expect_uo("program_mode", 8'h09);
        press(4'h9);
        press(4'h8);
        expect_uo("program_two_digits", 8'h29);
        press(4'h7);
        press(4'h6);
        tick(1);
        expect_uo("program_done", 8'h01);
        pulse(6);
        expect_uo("relock_after_prog", 8'h00);
        enter(16'h1234);
        expect_uo("old_code_rejected", 8'h42);
        enter(16'h9876);
        expect_uo("new_code_accepted", 8'h01);
        pulse(7);
        press(4'h5);
        pulse(5);
        expect_uo("program_clear_abort", 8'h01);
        ui_in[6] = 1'b1;
        ui_in[7] = 1'b1;
        tick(1);
        ui_in[6] = 1'b0;
        ui_in[7] = 1'b0;
        tick(3);
        expect_uo("relock_beats_program", 8'h00);
        enter(16'h9876);
        expect_uo("code_kept_after_abort", 8'h01);
        pulse(6);
    endtask

    task automatic test_reset_mid_entry;
        press(4'h1);
        press(4'h2);
        expect_uo("mid_entry", 8'h20);
        rst_n = 1'b0;
        #1;
        expect_uo("async_reset", 8'h00);
        #2;
        rst_n = 1'b1;
        tick(2);
        enter(16'h1234);
        expect_uo("default_code_restored", 8'h01);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset();
        test_unlock();
        test_wrong_then_right();
        test_lockout();
        test_clear();
        test_program();
        test_reset_mid_entry();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
